// File: rtl/bit_count_decoder.sv
// Sequential count-to-thermometer decoder: shifts min(Count, 8) ones into Result,
// one per clock, using the Start/Ready/Done handshake of the ones-counter.
module bit_count_decoder (
  input  logic       clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic [3:0] Count,
  output logic       Ready,
  output logic       Done,
  output logic [7:0] Result,
  output logic       Sat
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUILD = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t     state_r;
  logic [3:0] cnt_r;

  // Moore FSM; Ready/Done are registered alongside the state they decode
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_r <= S_IDLE;
      cnt_r   <= 4'd0;
      Result  <= 8'h00;
      Sat     <= 1'b0;
      Ready   <= 1'b1;
      Done    <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (Start) begin
            cnt_r   <= (Count > 4'd8) ? 4'd8 : Count;
            Result  <= 8'h00;
            Sat     <= (Count > 4'd8);
            state_r <= S_BUILD;
            Ready   <= 1'b0;
            Done    <= 1'b0;
          end else begin
            state_r <= S_IDLE;
            Ready   <= 1'b1;
            Done    <= 1'b0;
          end
        end
        S_BUILD: begin
          if (cnt_r != 4'd0) begin
            Result  <= {Result[6:0], 1'b1};
            cnt_r   <= cnt_r - 4'd1;
            state_r <= S_BUILD;
            Ready   <= 1'b0;
            Done    <= 1'b0;
          end else begin
            state_r <= S_DONE;
            Ready   <= 1'b0;
            Done    <= 1'b1;
          end
        end
        S_DONE: begin
          // Start must drop before a new operation can begin: no auto-restart
          if (Start) begin
            state_r <= S_DONE;
            Ready   <= 1'b0;
            Done    <= 1'b1;
          end else begin
            state_r <= S_IDLE;
            Ready   <= 1'b1;
            Done    <= 1'b0;
          end
        end
        default: begin
          state_r <= S_IDLE;
          cnt_r   <= 4'd0;
          Ready   <= 1'b1;
          Done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/bit_count_decoder.md
# bit_count_decoder

Sequential inverse of the team's ones-counter: given a 4-bit count of ones, it builds an 8-bit thermometer word with that many ones packed at the LSB end, shifting in one bit per clock. It uses the same Start/Ready/Done handshake as the counter, so one controller can drive either block. The main uses are round-trip checking of the counter (decoder output feeds counter input) and generating test patterns on the board.

## Interface
Parameters: none (word width fixed at 8, count width fixed at 4).

Ports:
- clk  input  1  system clock; all state changes on rising edge
- Reset  input  1  asynchronous, active-high; forces idle state immediately
- Start  input  1  request; sampled only in S_IDLE
- Count  input  4  number of ones to generate; sampled on the Start-capturing edge only
- Ready  output  1  high exactly while in S_IDLE
- Done  output  1  high exactly while in S_DONE
- Result  output  8  thermometer word being built / final result
- Sat  output  1  high if the captured Count exceeded 8 (clamped)

## Operation
- Three-state Moore FSM. Ready and Done decode the state only; no combinational path from the inputs.
- Internal 4-bit remaining counter cnt.
- **S_IDLE:** Ready=1.
  - Start=1 at an edge: cnt <= min(Count, 8); Result <= 8'h00; Sat <= (Count > 8); go to S_BUILD.
  - Start=0: hold. Result and Sat keep their last values.
- **S_BUILD:**
  - cnt != 0: Result <= {Result[6:0], 1'b1}; cnt <= cnt - 1.
  - cnt == 0: Result unchanged; go to S_DONE.
  - Start and Count are ignored.
- **S_DONE:** Done=1; Result and Sat held.
  - Start=1: stay in S_DONE.
  - Start=0: go to S_IDLE (Result and Sat still held).
- Arithmetic: Count values 9–15 clamp to 8, giving Result 8'hFF and Sat=1. Count=0 gives Result 8'h00.
- Reset (asynchronous, any state, including mid-build): state <= S_IDLE, Result <= 8'h00, cnt <= 0, Sat <= 0.
  - Reset outputs: Ready=1, Done=0, Result=8'h00, Sat=0.
  - The build in progress is discarded.

## Timing
- Edge E0 is the edge that samples Start=1 in S_IDLE. Ready falls after E0.
- Result updates after edges E1..EN, where N = min(Count, 8). After edge Ek, Result = (1<<k)-1.
- S_DONE is entered at edge E(N+1). Done is high from E(N+1) onward.
- Latency from E0 to Done: N+1 cycles. Examples: Count=0 takes 1 cycle; Count=8 takes 9 cycles; Count≥8 takes 9 cycles.
- Leaving S_DONE takes at least one cycle with Start=0. Ready returns the edge after Start is first sampled low.
- Start held high continuously: one operation only, then Done stays high. There is no automatic restart.
- A new Start is accepted on any edge while in S_IDLE, including the first edge after returning from S_DONE.
- Reset deasserting between edges: the first edge after deassertion is treated as a normal S_IDLE edge.

## Test plan
- Reset=1 for 1 cycle, then Reset=0 -> Ready=1, Done=0, Result=8'h00, Sat=0.
- Count=5; pulse Start 1 cycle at E0 -> Result steps 01,03,07,0F,1F after E1..E5; Done=1 after E6; Result=8'h1F, Sat=0; Ready=1 one cycle later.
- Count=0, then Count=8, then Count=12, each as a separate Start pulse -> Result 8'h00 with Done after E1; 8'hFF with Done after E9, Sat=0; 8'hFF with Done after E9, Sat=1.
- Count=3 with Start held high through completion, and Count changed to 7 during S_BUILD -> Result 8'h07, Done stays 1 while Start=1, no second run; after Start=0, Ready=1 next cycle and Result stays 8'h07.
- Count=6; assert Reset asynchronously (mid-cycle) after E3 -> Result=8'h00, Ready=1, Done=0 immediately, before the next edge; a following Start with Count=2 yields 8'h03 after E3.
- Round trip: feed Result into the ones-counter for Count=0..8 -> the counter's result equals min(Count, 8) in every case.
